// File: rtl/instr_fetch_port.sv
// -----------------------------------------------------------------------------
// instr_fetch_port
//   Instruction-side memory port between the PC/fetch stage and the
//   instruction memory. On a control-FSM request it reads the word at pc_cur
//   over a valid/ready request channel. It then waits a variable number of
//   cycles for the response and loads the instruction register. It reports
//   completion with fetch_done. It reports misalignment, out-of-range or
//   timeout with fetch_fault and fault_cause.
//
// Ports
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous active-high reset
//   cfsm__fetch_req  in   1   fetch request, honoured only while idle
//   pc_cur           in   32  address to fetch, sampled with the accepted request
//   imem_req_valid   out  1   read request valid
//   imem_req_ready   in   1   memory accepts the request
//   imem_req_addr    out  32  registered copy of the accepted pc_cur
//   imem_rsp_valid   in   1   read data valid
//   imem_rsp_data    in   32  read data
//   instr            out  32  instruction register
//   instr_pc         out  32  PC of the instruction held in instr
//   fetch_done       out  1   one-cycle pulse, instr/instr_pc were updated
//   fetch_fault      out  1   one-cycle pulse, fetch aborted
//   fault_cause      out  2   0 none, 1 misaligned, 2 out-of-range, 3 timeout
//   busy             out  1   a fetch is in progress
// -----------------------------------------------------------------------------
module instr_fetch_port #(
  parameter int unsigned IMEM_BYTES = 4096,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfsm__fetch_req,
  input  logic [31:0] pc_cur,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 32'd4);
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 32'd1);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_ALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE = 2'd2;
  localparam logic [1:0] CAUSE_TMO   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_valid_q, req_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cfsm__fetch_req) begin
          addr_d  = pc_cur;
          cause_d = CAUSE_NONE;
          // Misalignment is checked first so it wins over the range check.
          if (pc_cur[1:0] != 2'd0) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_ALIGN;
          end else if (pc_cur > LAST_ADDR) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_RANGE;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A response in the last allowed cycle still beats the timeout.
        if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = addr_q;
          state_d    = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TMO;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered: valid/busy follow the next state, while the
    // pulses fire in the cycle after DONE/FAULT is occupied.
    req_valid_d = (state_d == ST_REQ);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_q == ST_DONE);
    fault_d     = (state_q == ST_FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= 32'd0;
      cause_q     <= CAUSE_NONE;
      cnt_q       <= 8'd0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = addr_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign fetch_done     = done_q;
  assign fetch_fault    = fault_q;
  assign fault_cause    = cause_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_instr_fetch_port.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_port
//   Drives directed and random fetch transactions into instr_fetch_port. For
//   every accepted fetch, the bench computes the expected per-cycle timeline
//   of the outputs from the transaction parameters. Those parameters are the
//   accept cycle, the ready delay and the response delay. The timeline goes
//   into per-cycle expectation arrays. One compare process checks every
//   output against those arrays each cycle, plus hand-computed literal pins.
// -----------------------------------------------------------------------------
module tb_instr_fetch_port;

  localparam int MAXC = 4096;
  localparam int TMO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] pc_cur;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_done;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic        busy;

  instr_fetch_port #(
    .IMEM_BYTES(4096),
    .TIMEOUT   (TMO),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfsm__fetch_req(fetch_req),
    .pc_cur         (pc_cur),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_done     (fetch_done),
    .fetch_fault    (fetch_fault),
    .fault_cause    (fault_cause),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Cycle c is the period after the c-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle output timeline.
  bit          exp_busy  [MAXC];
  bit          exp_valid [MAXC];
  bit          exp_done  [MAXC];
  bit          exp_fault [MAXC];
  logic [31:0] exp_addr  [MAXC];
  logic [31:0] exp_instr [MAXC];
  logic [31:0] exp_ipc   [MAXC];
  logic [1:0]  exp_cause [MAXC];

  // Hand-computed literal expectations at chosen cycles.
  bit          pin_en    [MAXC];
  logic [31:0] pin_instr [MAXC];
  logic [31:0] pin_ipc   [MAXC];
  logic [1:0]  pin_cause [MAXC];
  bit          pin_done  [MAXC];
  bit          pin_fault [MAXC];
  bit          pin_busy  [MAXC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: actual %h required %h", nm, cyc, act, req);
    end
  endtask

  // Compare process: checks all outputs every cycle, away from the edge.
  always @(posedge clk) begin
    #1;
    if (cyc >= 1 && cyc < MAXC) begin
      chk("busy",        {31'd0, busy},           {31'd0, exp_busy[cyc]});
      chk("req_valid",   {31'd0, imem_req_valid}, {31'd0, exp_valid[cyc]});
      chk("req_addr",    imem_req_addr,           exp_addr[cyc]);
      chk("instr",       instr,                   exp_instr[cyc]);
      chk("instr_pc",    instr_pc,                exp_ipc[cyc]);
      chk("fetch_done",  {31'd0, fetch_done},     {31'd0, exp_done[cyc]});
      chk("fetch_fault", {31'd0, fetch_fault},    {31'd0, exp_fault[cyc]});
      chk("fault_cause", {30'd0, fault_cause},    {30'd0, exp_cause[cyc]});
      if (pin_en[cyc]) begin
        chk("pin_instr",    instr,                {30'd0, 2'd0} | pin_instr[cyc]);
        chk("pin_instr_pc", instr_pc,             pin_ipc[cyc]);
        chk("pin_cause",    {30'd0, fault_cause}, {30'd0, pin_cause[cyc]});
        chk("pin_done",     {31'd0, fetch_done},  {31'd0, pin_done[cyc]});
        chk("pin_fault",    {31'd0, fetch_fault}, {31'd0, pin_fault[cyc]});
        chk("pin_busy",     {31'd0, busy},        {31'd0, pin_busy[cyc]});
      end
    end
  end

  task automatic pin(input int c, input logic [31:0] i, input logic [31:0] p,
                     input logic [1:0] cz, input bit d, input bit f, input bit b);
    if (c < MAXC) begin
      pin_en[c]    = 1'b1;
      pin_instr[c] = i;
      pin_ipc[c]   = p;
      pin_cause[c] = cz;
      pin_done[c]  = d;
      pin_fault[c] = f;
      pin_busy[c]  = b;
    end
  endtask

  task automatic idle_drive();
    reset          = 1'b0;
    fetch_req      = 1'b0;
    pc_cur         = $urandom();
    imem_req_ready = 1'($urandom_range(0, 1));
    imem_rsp_valid = 1'($urandom_range(0, 1));
    imem_rsp_data  = $urandom();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      idle_drive();
      @(negedge clk);
    end
    idle_drive();
  endtask

  // One fetch accepted in the current cycle k (the DUT must be idle).
  // r: cycles of ready low in REQ; d: WAIT cycles before the response
  // (d >= TMO means no response); abort: cycles after accept at which reset
  // is raised (0 none, negative picks a random point inside the fetch).
  task automatic fetch(input logic [31:0] pc, input int r, input int d,
                       input logic [31:0] data, input int abort);
    int k, w0, wend, rsp_c, last, endc, ab;
    bit bad, tmo;
    logic [1:0] cz;
    k     = cyc;
    bad   = (pc[1:0] != 2'd0) || (pc > 32'd4092);
    cz    = (pc[1:0] != 2'd0) ? 2'd1 : ((pc > 32'd4092) ? 2'd2 : 2'd0);
    tmo   = (d >= TMO);
    w0    = k + 2 + r;
    rsp_c = w0 + d;
    wend  = tmo ? (w0 + TMO - 1) : rsp_c;
    if (bad)      last = k + 1;
    else if (tmo) last = w0 + TMO;
    else          last = rsp_c + 1;
    ab = abort;
    if (ab < 0) ab = $urandom_range(1, last - k);

    for (int c = k + 1; c < MAXC; c++) begin
      exp_addr[c]  = pc;
      exp_cause[c] = cz;
    end
    for (int c = k + 1; c <= last && c < MAXC; c++) exp_busy[c] = 1'b1;
    if (!bad) for (int c = k + 1; c <= k + 1 + r && c < MAXC; c++) exp_valid[c] = 1'b1;
    if (last + 1 < MAXC) begin
      if (bad || tmo) exp_fault[last + 1] = 1'b1;
      else            exp_done[last + 1]  = 1'b1;
    end
    if (!bad && tmo) for (int c = last; c < MAXC; c++) exp_cause[c] = 2'd3;
    if (!bad && !tmo) for (int c = last; c < MAXC; c++) begin
      exp_instr[c] = data;
      exp_ipc[c]   = pc;
    end
    if (ab > 0) begin
      endc = k + ab;
      for (int c = endc + 1; c < MAXC; c++) begin
        exp_busy[c]  = 1'b0;
        exp_valid[c] = 1'b0;
        exp_done[c]  = 1'b0;
        exp_fault[c] = 1'b0;
        exp_addr[c]  = 32'd0;
        exp_instr[c] = NOP;
        exp_ipc[c]   = 32'd0;
        exp_cause[c] = 2'd0;
      end
    end else begin
      endc = last;
    end

    reset          = 1'b0;
    fetch_req      = 1'b1;
    pc_cur         = pc;
    imem_req_ready = 1'($urandom_range(0, 1));
    imem_rsp_valid = 1'($urandom_range(0, 1));
    imem_rsp_data  = $urandom();
    for (int c = k + 1; c <= endc; c++) begin
      @(negedge clk);
      reset     = (ab > 0) && (c == endc);
      fetch_req = 1'($urandom_range(0, 1));
      pc_cur    = $urandom();
      if (!bad && c <= k + r)       imem_req_ready = 1'b0;
      else if (!bad && c == k + 1 + r) imem_req_ready = 1'b1;
      else                          imem_req_ready = 1'($urandom_range(0, 1));
      if (!bad && c >= w0 && c <= wend) imem_rsp_valid = !tmo && (c == rsp_c);
      else                              imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data = (!bad && c == rsp_c) ? data : $urandom();
    end
    @(negedge clk);
    idle_drive();
  endtask

  initial begin
    int k;
    int n;
    logic [31:0] pc;
    for (int c = 0; c < MAXC; c++) begin
      exp_busy[c]  = 1'b0;
      exp_valid[c] = 1'b0;
      exp_done[c]  = 1'b0;
      exp_fault[c] = 1'b0;
      exp_addr[c]  = 32'd0;
      exp_instr[c] = NOP;
      exp_ipc[c]   = 32'd0;
      exp_cause[c] = 2'd0;
      pin_en[c]    = 1'b0;
    end
    reset          = 1'b1;
    fetch_req      = 1'b1;
    pc_cur         = 32'h40;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    pin(1, 32'h13, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle(2);

    // Basic fetch, minimum latency.
    k = cyc;
    pin(k + 4, 32'h0050_0093, 32'h8, 2'd0, 1'b1, 1'b0, 1'b0);
    fetch(32'h8, 0, 0, 32'h0050_0093, 0);
    idle(1);

    // Backpressure and longer latency at the last legal word.
    k = cyc;
    pin(k + 11, 32'h00A0_0113, 32'hFFC, 2'd0, 1'b1, 1'b0, 1'b0);
    fetch(32'hFFC, 3, 4, 32'h00A0_0113, 0);

    // Address faults.
    k = cyc; pin(k + 2, 32'h00A0_0113, 32'hFFC, 2'd1, 1'b0, 1'b1, 1'b0);
    fetch(32'h6, 0, 0, 32'h0, 0);
    k = cyc; pin(k + 2, 32'h00A0_0113, 32'hFFC, 2'd2, 1'b0, 1'b1, 1'b0);
    fetch(32'h1000, 0, 0, 32'h0, 0);
    k = cyc; pin(k + 2, 32'h00A0_0113, 32'hFFC, 2'd1, 1'b0, 1'b1, 1'b0);
    fetch(32'h1002, 0, 0, 32'h0, 0);
    k = cyc; pin(k + 2, 32'h00A0_0113, 32'hFFC, 2'd2, 1'b0, 1'b1, 1'b0);
    fetch(32'hFFFF_FFFC, 0, 0, 32'h0, 0);

    // Timeout: no response ever, then stray responses while idle.
    k = cyc; pin(k + 11, 32'h00A0_0113, 32'hFFC, 2'd3, 1'b0, 1'b1, 1'b0);
    fetch(32'h100, 0, 50, 32'h0, 0);
    idle(5);

    // Reset mid-WAIT, stale responses afterwards, then a clean fetch.
    k = cyc; pin(k + 5, 32'h13, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    fetch(32'h20, 0, 6, 32'h1234_5678, 4);
    idle(6);
    k = cyc; pin(k + 4, 32'h0000_0513, 32'h10, 2'd0, 1'b1, 1'b0, 1'b0);
    fetch(32'h10, 0, 0, 32'h0000_0513, 0);

    // Random transactions.
    n = 0;
    while (n < 80 && cyc < MAXC - 100) begin
      case ($urandom_range(0, 7))
        0:       pc = 32'hFFC;
        1:       pc = 32'h1000;
        2:       pc = 32'hFFFF_FFFC;
        3:       pc = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        4:       pc = $urandom();
        default: pc = {20'd0, 10'($urandom_range(0, 1023)), 2'd0};
      endcase
      fetch(pc, $urandom_range(0, 4), $urandom_range(0, 10), $urandom(),
            ($urandom_range(0, 9) == 0) ? -1 : 0);
      idle($urandom_range(0, 3));
      n++;
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
